// File: rtl/pack_fifo_pkg.sv
// Shared defaults and helpers for the pack_fifo byte-to-word FIFO.
package pack_fifo_pkg;

  localparam int DATA_W_D = 8;
  localparam int LANES_D  = 15;
  localparam int DEPTH_D  = 4;

  function automatic int lane_cnt_w(input int lanes);
    return $clog2(lanes + 1);
  endfunction

endpackage

// File: rtl/pack_fifo_byte_packer.sv
// byte_packer: collects bytes MS-lane first into a word and requests a push
// when the word completes or a flush hits a non-empty packer.
module byte_packer
  import pack_fifo_pkg::*;
#(
  parameter int DATA_W = DATA_W_D,
  parameter int LANES  = LANES_D,
  parameter int LCW    = lane_cnt_w(LANES)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [DATA_W-1:0]        wdata,
  input  logic                     winc,
  input  logic                     flush,
  input  logic                     room,
  output logic                     full,
  output logic                     push,
  output logic [DATA_W*LANES-1:0]  push_data,
  output logic [LCW-1:0]           push_lanes
);

  localparam int W = DATA_W * LANES;
  localparam logic [LCW-1:0] LAST = LCW'(LANES - 1);

  logic [W-1:0]   shreg;
  logic [W-1:0]   merged;
  logic [LCW-1:0] lane_cnt;
  logic           accept;
  int             slot;

  always_comb begin
    full       = !room && (lane_cnt == LAST);
    accept     = winc && !full;
    slot       = (LANES - 1 - int'(lane_cnt)) * DATA_W;
    merged     = shreg;
    if (accept) merged[slot +: DATA_W] = wdata;
    push_lanes = accept ? lane_cnt + LCW'(1) : lane_cnt;
    // A byte that completes the word pushes by itself; a flush only adds a push when there is room.
    push       = (accept && lane_cnt == LAST) || (flush && room && push_lanes != '0);
    push_data  = merged;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      shreg    <= '0;
      lane_cnt <= '0;
    end else if (push) begin
      shreg    <= '0;
      lane_cnt <= '0;
    end else if (accept) begin
      shreg    <= merged;
      lane_cnt <= lane_cnt + LCW'(1);
    end
  end

endmodule

// File: rtl/pack_fifo.sv
// pack_fifo: packs a byte stream into LANES-byte words and buffers DEPTH words show-ahead.
// Optional almost_full flag enabled by defining PACK_FIFO_ALMOST_FULL_EN.
module pack_fifo
  import pack_fifo_pkg::*;
#(
  parameter int DATA_W    = DATA_W_D,
  parameter int LANES     = LANES_D,
  parameter int DEPTH     = DEPTH_D,
  parameter int AF_THRESH = 3
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [DATA_W-1:0]              wdata,
  input  logic                           winc,
  input  logic                           flush,
  input  logic                           rinc,
  input  logic                           clr_err,
  output logic [DATA_W*LANES-1:0]        data_out,
  output logic [lane_cnt_w(LANES)-1:0]   lanes_valid,
  output logic                           full,
  output logic                           empty,
  output logic                           almost_full,
  output logic                           overflow,
  output logic                           underflow
);

  localparam int W   = DATA_W * LANES;
  localparam int LCW = lane_cnt_w(LANES);
  localparam int PW  = $clog2(DEPTH);
  localparam int CW  = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("pack_fifo: DEPTH must be a power of 2 and at least 2");
  end
  if (AF_THRESH < 1 || AF_THRESH > DEPTH) begin : g_bad_thresh
    $error("pack_fifo: AF_THRESH must be within 1..DEPTH");
  end

  // Handshake: winc is a strobe taken whenever full is low (dropped and flagged otherwise);
  // rinc pops the head when empty is low (ignored and flagged otherwise).
  logic [W-1:0]   mem_data  [DEPTH];
  logic [LCW-1:0] mem_lanes [DEPTH];
  logic [PW-1:0]  wr_ptr, rd_ptr;
  logic [CW-1:0]  count, count_nxt;
  logic           empty_q;
  logic           push, pop;
  logic [W-1:0]   push_data;
  logic [LCW-1:0] push_lanes;

  byte_packer #(.DATA_W(DATA_W), .LANES(LANES), .LCW(LCW)) u_packer (
    .clk        (clk),
    .rst        (rst),
    .wdata      (wdata),
    .winc       (winc),
    .flush      (flush),
    .room       (count != DEPTH_C),
    .full       (full),
    .push       (push),
    .push_data  (push_data),
    .push_lanes (push_lanes)
  );

  always_comb begin
    pop       = rinc && !empty_q;
    count_nxt = count;
    case ({push, pop})
      2'b10:   count_nxt = count + CW'(1);
      2'b01:   count_nxt = count - CW'(1);
      default: count_nxt = count;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_data[wr_ptr]  <= push_data;
      mem_lanes[wr_ptr] <= push_lanes;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      empty_q   <= 1'b1;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      count   <= count_nxt;
      empty_q <= (count_nxt == '0);
      // Set beats clear when an error lands in the same cycle as clr_err.
      if (winc && full)       overflow <= 1'b1;
      else if (clr_err)       overflow <= 1'b0;
      if (rinc && empty_q)    underflow <= 1'b1;
      else if (clr_err)       underflow <= 1'b0;
    end
  end

`ifdef PACK_FIFO_ALMOST_FULL_EN
  localparam logic [CW-1:0] AF_C = CW'(AF_THRESH);
  logic af_q;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) af_q <= 1'b0;
    else      af_q <= (count_nxt >= AF_C);
  end
  assign almost_full = af_q;
`else
  assign almost_full = 1'b0;
`endif

  assign empty       = empty_q;
  assign data_out    = empty_q ? '0 : mem_data[rd_ptr];
  assign lanes_valid = empty_q ? '0 : mem_lanes[rd_ptr];

endmodule

// File: doc/pack_fifo.md
Name: pack_fifo

Overview:
- Parametrised successor to the byte-in / wide-word-out FIFO on the SPI data-out path.
- Accepts a DATA_W-bit byte stream and packs LANES bytes into one word.
- Buffers up to DEPTH packed words and presents the head word show-ahead to the downstream reader.
- Adds full/empty flags, partial-word flush with a lane count, sticky error flags and an optional almost-full flag.

Parameters:
- DATA_W, 8: width of one input lane.
- LANES, 15: lanes per packed word; word width is DATA_W*LANES (default 120).
- DEPTH, 4: packed-word storage entries; must be a power of 2, at least 2.
- AF_THRESH, 3: almost_full asserts when stored words ≥ AF_THRESH; must be 1..DEPTH.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- wdata  in  DATA_W  input byte.
- winc  in  1  write strobe; one byte per cycle.
- flush  in  1  push a partially filled word.
- rinc  in  1  pop the head word.
- clr_err  in  1  synchronous clear of the sticky errors.
- data_out  out  DATA_W*LANES  head word, show-ahead.
- lanes_valid  out  $clog2(LANES+1)  valid lanes in the head word.
- full  out  1  next byte cannot be accepted.
- empty  out  1  no stored word.
- almost_full  out  1  stored words ≥ AF_THRESH.
- overflow  out  1  sticky: byte dropped.
- underflow  out  1  sticky: rinc while empty.

Behaviour:
- Reset (rst=0, async): lane_cnt=0, word count=0, pointers=0, packer=0, data_out=0, lanes_valid=0, empty=1, full=0, almost_full=0, overflow=0, underflow=0.
- Lane order: first byte of a word goes to the MS lane, data_out[DATA_W*LANES-1 -: DATA_W]; later bytes fill downward.
- Partial words are left-justified with unused lanes zero.
- Packer: winc && !full stores wdata in lane lane_cnt.
  - If lane_cnt==LANES-1, the completed word (lanes_valid=LANES) is written to storage at the same edge and lane_cnt returns to 0.
  - Otherwise lane_cnt increments.
- full = (count==DEPTH) && (lane_cnt==LANES-1). The packer can hold LANES-1 bytes while storage is full.
- winc while full: byte dropped, state unchanged, overflow set next edge.
- flush with lane_cnt>0 and count<DEPTH: push the packer contents with lanes_valid=lane_cnt, then lane_cnt=0.
- flush with lane_cnt==0 and no winc: no-op.
- flush while count==DEPTH: ignored and not an error; packer retained.
- winc and flush in the same cycle: the byte is packed first, then the flush pushes lane_cnt+1 lanes. A completing byte makes the flush redundant; exactly one word is pushed.
- Read: when !empty, data_out/lanes_valid show the head entry combinationally from storage. rinc && !empty pops at the edge.
- rinc while empty: ignored; underflow set. When empty, data_out=0 and lanes_valid=0.
- Simultaneous push and pop: count is unchanged and both pointers advance.
  - full/push eligibility uses the registered count, so a push blocked at count==DEPTH is not rescued by a same-cycle rinc.
- Pointers: $clog2(DEPTH) bits, natural wrap.
- Flag timing: empty, almost_full and count are registered.
  - A word pushed at edge k clears empty after edge k.
  - A pop at edge k updates the flags after edge k.
- clr_err clears overflow/underflow. If an error event occurs in the same cycle, the set wins.
- Reset asserted mid-operation discards all stored and partial data immediately.

Optional Feature:
- Macro PACK_FIFO_ALMOST_FULL_EN.
- Defined: almost_full is driven as specified, registered from count.
- Undefined: almost_full is tied to 0 and AF_THRESH is unused. No other behaviour changes.

Decomposition:
- Package pack_fifo_pkg holds:
  - default constants DATA_W_D=8, LANES_D=15, DEPTH_D=4;
  - function lane_cnt_w(LANES) returning $clog2(LANES+1).
- Sub-module byte_packer owns lane_cnt, the shift/lane register and the flush/complete push request.
- pack_fifo holds the storage array, pointers, count, flags and errors.

Test Plan:
- Reset then write 15 bytes 1..15 → after the 15th edge empty=0, lanes_valid=15, data_out MS byte=1, LS byte=15.
- Write 1,2,3 then flush → lanes_valid=3, data_out[119:96]=0x010203, remaining 96 bits=0; rinc → empty=1, data_out=0.
- Fill 4 words plus 14 bytes → full=1. Extra winc → overflow=1 and the next word is unchanged. One rinc → full=0; the next byte completes word 5.
- rinc while empty → underflow=1. clr_err same cycle as a further empty rinc → underflow stays 1. clr_err alone → 0.
- Simultaneous push and pop at count=2 → count stays 2, FIFO order preserved across pointer wrap after 10 words. almost_full=1 at count≥3 with the macro defined, 0 without.
- Drop rst mid-word (lane_cnt=7, count=2) → all outputs at reset values asynchronously; the first post-reset word contains only new bytes.
